riscv_hazard_ctrl: RTL and testbench
====================================

Name: riscv_hazard_ctrl

Overview:
Central pipeline hazard controller for the 5-stage RV32IM core. Sequences stalls and flushes of the PC, IF/ID, ID/EX and EX/MEM registers for load-use hazards, branch mispredicts, traps and the multi-cycle MUL/DIV unit (MDU). Generates the operand-forwarding selects for the instruction in EX and maintains the stall performance counter. It sits beside the datapath and drives only control signals.

Parameters:
FLUSH_CYCLES, 1, total cycles flush_ifid_o is held after a redirect, including the detection cycle; must be >= 1.
MDU_TIMEOUT, 64, consecutive MDU_BUSY cycles without mdu_done_i before the op is aborted; must be >= 2.

Ports:
clk_i  input  1  core clock
rst_i  input  1  synchronous, active-high reset
id_valid_i  input  1  valid instruction in ID
id_rs1_addr_i / id_rs2_addr_i  input  5 each  ID source registers
id_rs1_used_i / id_rs2_used_i  input  1 each  ID instruction reads rs1 / rs2
ex_valid_i  input  1  valid instruction in EX
ex_rs1_addr_i / ex_rs2_addr_i  input  5 each  EX source registers
ex_rd_addr_i  input  5  EX destination
ex_mem_read_i  input  1  EX instruction is a load
ex_is_mdu_i  input  1  EX instruction is MUL/DIV
ex_mispredict_i  input  1  EX branch/jump resolved mispredicted
mem_valid_i, mem_reg_write_i  input  1 each  MEM instruction valid / writes rd
mem_rd_addr_i  input  5  MEM destination
wb_valid_i, wb_reg_write_i  input  1 each  WB instruction valid / writes rd
wb_rd_addr_i  input  5  WB destination
trap_i  input  1  exception/interrupt taken
mdu_done_i  input  1  MDU result valid this cycle
mdu_start_o  output  1  one-cycle MDU start pulse
mdu_abort_o  output  1  one-cycle MDU abort pulse
mdu_timeout_o  output  1  sticky MDU watchdog error
stall_pc_o, stall_ifid_o, stall_idex_o  output  1 each  hold register
flush_ifid_o, flush_idex_o, flush_exmem_o  output  1 each  load bubble into register
rs1_fwd_sel_o / rs2_fwd_sel_o  output  2 each  forwarding select for the EX operand
stall_cnt_o  output  32  cycles with stall_pc_o = 1

Behaviour:
- Reset: state RUN, flush and busy counters 0, mdu_timeout_o 0, stall_cnt_o 0. While rst_i = 1, all stall, start and abort outputs are 0, all flush outputs are 1, and fwd selects are 00.
- Forwarding (combinational, every state): rsX_fwd_sel_o = 01 (FWD_SEL_MEM) if mem_valid_i & mem_reg_write_i & mem_rd != 0 & mem_rd == ex_rsX; else 10 (FWD_SEL_WB) under the same test on WB; else 00 (FWD_SEL_REG). MEM has priority over WB.
- Event priority: trap > mispredict > MDU > load-use.
- RUN:
  - trap_i: flush_ifid/idex/exmem = 1; enter FLUSH if FLUSH_CYCLES > 1.
  - ex_mispredict_i: flush_ifid and flush_idex = 1 (the branch proceeds to MEM); enter FLUSH if FLUSH_CYCLES > 1.
  - ex_valid_i & ex_is_mdu_i: mdu_start_o = 1; stall_pc, stall_ifid and stall_idex = 1; flush_exmem = 1; busy counter cleared; go to MDU_BUSY.
  - Load-use (id_valid_i & ex_valid_i & ex_mem_read_i & ex_rd != 0 & a used ID source equals ex_rd): stall_pc and stall_ifid = 1 and flush_idex = 1 for exactly one cycle; state stays RUN.
- FLUSH: flush_ifid = 1 only; the counter runs FLUSH_CYCLES-1 cycles, then the block returns to RUN. A trap in FLUSH re-applies the trap flushes and restarts the count. Mispredict and MDU inputs are ignored.
- MDU_BUSY:
  - No done: stall_pc/ifid/idex = 1, flush_exmem = 1, busy counter increments.
  - mdu_done_i: all stalls and flushes = 0 (result captured into EX/MEM this edge); go to RUN. No re-start is issued for the same op.
  - Busy counter reaches MDU_TIMEOUT with no done (in the MDU_TIMEOUT-th busy cycle): mdu_abort_o = 1, mdu_timeout_o set (sticky until reset), stalls = 0, flush_exmem = 1; go to RUN.
  - trap_i (priority over done/timeout): mdu_abort_o = 1, trap flushes, stalls = 0; go to FLUSH if FLUSH_CYCLES > 1, else RUN.
- stall_cnt_o: increments by 1 in every cycle with stall_pc_o = 1; wraps modulo 2^32.
- Reset mid-operation (any state): the block returns to RUN on the next edge and no abort pulse is generated.

Test Plan:
- Load-use: EX = lw x5, ID = add x6,x5,x1 -> exactly one cycle of stall_pc = stall_ifid = flush_idex = 1; with add then in EX and lw in WB, rs1_fwd_sel_o = 10; stall_cnt_o +1.
- Forwarding: MEM rd = 3, WB rd = 3, ex_rs1 = 3 -> rs1 sel 01. MEM reg_write = 0 -> 10. All rd = 0 -> 00.
- Mispredict, FLUSH_CYCLES = 3: cycle 0 flush_ifid = flush_idex = 1; cycles 1-2 flush_ifid only; cycle 3 all flushes 0, state RUN.
- MDU, done 5 cycles after start: start pulse at t0, stalls t0-t4, released at t5, no second start, stall_cnt_o +5.
- MDU_TIMEOUT = 8, no done: abort pulse and flush_exmem in busy cycle 8, mdu_timeout_o = 1 and stays 1 until rst_i.
- Trap in MDU_BUSY -> abort pulse plus all three flushes. Separately, rst_i asserted mid-busy -> RUN, counters 0, no abort.

Source files
------------

// File: rtl/riscv_hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32IM core: stall/flush
// sequencing for load-use, mispredict, trap and multi-cycle MDU ops, plus
// EX operand forwarding selects and a stall performance counter.
module riscv_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MDU_TIMEOUT  = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        id_valid_i,
    input  logic [4:0]  id_rs1_addr_i,
    input  logic [4:0]  id_rs2_addr_i,
    input  logic        id_rs1_used_i,
    input  logic        id_rs2_used_i,
    input  logic        ex_valid_i,
    input  logic [4:0]  ex_rs1_addr_i,
    input  logic [4:0]  ex_rs2_addr_i,
    input  logic [4:0]  ex_rd_addr_i,
    input  logic        ex_mem_read_i,
    input  logic        ex_is_mdu_i,
    input  logic        ex_mispredict_i,
    input  logic        mem_valid_i,
    input  logic        mem_reg_write_i,
    input  logic [4:0]  mem_rd_addr_i,
    input  logic        wb_valid_i,
    input  logic        wb_reg_write_i,
    input  logic [4:0]  wb_rd_addr_i,
    input  logic        trap_i,
    input  logic        mdu_done_i,
    output logic        mdu_start_o,
    output logic        mdu_abort_o,
    output logic        mdu_timeout_o,
    output logic        stall_pc_o,
    output logic        stall_ifid_o,
    output logic        stall_idex_o,
    output logic        flush_ifid_o,
    output logic        flush_idex_o,
    output logic        flush_exmem_o,
    output logic [1:0]  rs1_fwd_sel_o,
    output logic [1:0]  rs2_fwd_sel_o,
    output logic [31:0] stall_cnt_o
);

    localparam logic [1:0] FWD_SEL_REG = 2'b00;
    localparam logic [1:0] FWD_SEL_MEM = 2'b01;
    localparam logic [1:0] FWD_SEL_WB  = 2'b10;

    // Flush counter only has to reach FLUSH_CYCLES-2; busy counter MDU_TIMEOUT-1.
    localparam int FCW = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int BCW = $clog2(MDU_TIMEOUT);
    localparam bit FLUSH_HOLD = (FLUSH_CYCLES > 1);
    localparam logic [FCW-1:0] FLUSH_LAST = FCW'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);
    localparam logic [BCW-1:0] BUSY_LAST  = BCW'(MDU_TIMEOUT - 1);

    typedef enum logic [1:0] {RUN, FLUSH, MDU_BUSY} state_e;

    state_e         state, state_n;
    logic [FCW-1:0] flush_cnt, flush_cnt_n;
    logic [BCW-1:0] busy_cnt, busy_cnt_n;
    logic           timeout_set;
    logic           load_use;

    // Forwarding for both EX operands; MEM result is younger so it wins over WB.
    logic [1:0][4:0] ex_rs;
    logic [1:0][1:0] fwd_sel;
    assign ex_rs = {ex_rs2_addr_i, ex_rs1_addr_i};

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_fwd
            // Per-operand source select
            always_comb begin
                fwd_sel[g] = FWD_SEL_REG;
                if (rst_i)
                    fwd_sel[g] = FWD_SEL_REG;
                else if (mem_valid_i && mem_reg_write_i && (mem_rd_addr_i != 5'd0) &&
                         (mem_rd_addr_i == ex_rs[g]))
                    fwd_sel[g] = FWD_SEL_MEM;
                else if (wb_valid_i && wb_reg_write_i && (wb_rd_addr_i != 5'd0) &&
                         (wb_rd_addr_i == ex_rs[g]))
                    fwd_sel[g] = FWD_SEL_WB;
            end
        end
    endgenerate

    assign rs1_fwd_sel_o = fwd_sel[0];
    assign rs2_fwd_sel_o = fwd_sel[1];

    assign load_use = id_valid_i && ex_valid_i && ex_mem_read_i && (ex_rd_addr_i != 5'd0) &&
                      ((id_rs1_used_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                       (id_rs2_used_i && (id_rs2_addr_i == ex_rd_addr_i)));

    // State, counters and sticky watchdog flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= RUN;
            flush_cnt     <= '0;
            busy_cnt      <= '0;
            mdu_timeout_o <= 1'b0;
        end else begin
            state     <= state_n;
            flush_cnt <= flush_cnt_n;
            busy_cnt  <= busy_cnt_n;
            if (timeout_set)
                mdu_timeout_o <= 1'b1;
        end
    end

    // Next state and control outputs; event priority trap > mispredict > MDU > load-use
    always_comb begin
        state_n       = state;
        flush_cnt_n   = flush_cnt;
        busy_cnt_n    = busy_cnt;
        timeout_set   = 1'b0;
        mdu_start_o   = 1'b0;
        mdu_abort_o   = 1'b0;
        stall_pc_o    = 1'b0;
        stall_ifid_o  = 1'b0;
        stall_idex_o  = 1'b0;
        flush_ifid_o  = 1'b0;
        flush_idex_o  = 1'b0;
        flush_exmem_o = 1'b0;

        unique case (state)
            RUN: begin
                if (trap_i) begin
                    {flush_ifid_o, flush_idex_o, flush_exmem_o} = 3'b111;
                    flush_cnt_n = '0;
                    if (FLUSH_HOLD) state_n = FLUSH;
                end else if (ex_mispredict_i) begin
                    // The branch itself survives into MEM
                    {flush_ifid_o, flush_idex_o} = 2'b11;
                    flush_cnt_n = '0;
                    if (FLUSH_HOLD) state_n = FLUSH;
                end else if (ex_valid_i && ex_is_mdu_i) begin
                    mdu_start_o = 1'b1;
                    {stall_pc_o, stall_ifid_o, stall_idex_o} = 3'b111;
                    flush_exmem_o = 1'b1;
                    busy_cnt_n    = '0;
                    state_n       = MDU_BUSY;
                end else if (load_use) begin
                    {stall_pc_o, stall_ifid_o} = 2'b11;
                    flush_idex_o = 1'b1;
                end
            end
            FLUSH: begin
                flush_ifid_o = 1'b1;
                if (trap_i) begin
                    {flush_idex_o, flush_exmem_o} = 2'b11;
                    flush_cnt_n = '0;
                end else if (flush_cnt == FLUSH_LAST) begin
                    state_n = RUN;
                end else begin
                    flush_cnt_n = flush_cnt + 1'b1;
                end
            end
            MDU_BUSY: begin
                if (trap_i) begin
                    mdu_abort_o = 1'b1;
                    {flush_ifid_o, flush_idex_o, flush_exmem_o} = 3'b111;
                    flush_cnt_n = '0;
                    state_n     = FLUSH_HOLD ? FLUSH : RUN;
                end else if (mdu_done_i) begin
                    // Result is captured into EX/MEM on this edge
                    state_n = RUN;
                end else if (busy_cnt == BUSY_LAST) begin
                    mdu_abort_o   = 1'b1;
                    flush_exmem_o = 1'b1;
                    timeout_set   = 1'b1;
                    state_n       = RUN;
                end else begin
                    {stall_pc_o, stall_ifid_o, stall_idex_o} = 3'b111;
                    flush_exmem_o = 1'b1;
                    busy_cnt_n    = busy_cnt + 1'b1;
                end
            end
            default: state_n = RUN;
        endcase

        // Reset forces bubbles everywhere and suppresses any abort
        if (rst_i) begin
            mdu_start_o   = 1'b0;
            mdu_abort_o   = 1'b0;
            stall_pc_o    = 1'b0;
            stall_ifid_o  = 1'b0;
            stall_idex_o  = 1'b0;
            flush_ifid_o  = 1'b1;
            flush_idex_o  = 1'b1;
            flush_exmem_o = 1'b1;
        end
    end

    // Stall performance counter, wraps naturally
    always_ff @(posedge clk_i) begin
        if (rst_i)
            stall_cnt_o <= '0;
        else if (stall_pc_o)
            stall_cnt_o <= stall_cnt_o + 32'd1;
    end

endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// Directed self-checking bench for riscv_hazard_ctrl (FLUSH_CYCLES=3, MDU_TIMEOUT=8).
module tb_riscv_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_rs1_used, id_rs2_used;
    logic [4:0]  id_rs1, id_rs2;
    logic        ex_valid, ex_mem_read, ex_is_mdu, ex_mispredict;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic        mem_valid, mem_reg_write, wb_valid, wb_reg_write;
    logic [4:0]  mem_rd, wb_rd;
    logic        trap, mdu_done;
    logic        mdu_start, mdu_abort, mdu_timeout;
    logic        stall_pc, stall_ifid, stall_idex;
    logic        flush_ifid, flush_idex, flush_exmem;
    logic [1:0]  rs1_sel, rs2_sel;
    logic [31:0] stall_cnt;
    logic [7:0]  ctl;

    int vectors = 0;
    int errs    = 0;

    riscv_hazard_ctrl #(.FLUSH_CYCLES(3), .MDU_TIMEOUT(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .id_valid_i(id_valid), .id_rs1_addr_i(id_rs1), .id_rs2_addr_i(id_rs2),
        .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
        .ex_valid_i(ex_valid), .ex_rs1_addr_i(ex_rs1), .ex_rs2_addr_i(ex_rs2),
        .ex_rd_addr_i(ex_rd), .ex_mem_read_i(ex_mem_read), .ex_is_mdu_i(ex_is_mdu),
        .ex_mispredict_i(ex_mispredict),
        .mem_valid_i(mem_valid), .mem_reg_write_i(mem_reg_write), .mem_rd_addr_i(mem_rd),
        .wb_valid_i(wb_valid), .wb_reg_write_i(wb_reg_write), .wb_rd_addr_i(wb_rd),
        .trap_i(trap), .mdu_done_i(mdu_done),
        .mdu_start_o(mdu_start), .mdu_abort_o(mdu_abort), .mdu_timeout_o(mdu_timeout),
        .stall_pc_o(stall_pc), .stall_ifid_o(stall_ifid), .stall_idex_o(stall_idex),
        .flush_ifid_o(flush_ifid), .flush_idex_o(flush_idex), .flush_exmem_o(flush_exmem),
        .rs1_fwd_sel_o(rs1_sel), .rs2_fwd_sel_o(rs2_sel), .stall_cnt_o(stall_cnt)
    );

    // {stall_pc, stall_ifid, stall_idex, flush_ifid, flush_idex, flush_exmem, start, abort}
    assign ctl = {stall_pc, stall_ifid, stall_idex, flush_ifid, flush_idex, flush_exmem,
                  mdu_start, mdu_abort};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then let inputs be changed away from the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs1_used = 0; id_rs2_used = 0; id_rs1 = 0; id_rs2 = 0;
        ex_valid = 0; ex_mem_read = 0; ex_is_mdu = 0; ex_mispredict = 0;
        ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0;
        mem_valid = 0; mem_reg_write = 0; mem_rd = 0;
        wb_valid = 0; wb_reg_write = 0; wb_rd = 0;
        trap = 0; mdu_done = 0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst = 1;
        // Forwarding hit present during reset must still read 00
        mem_valid = 1; mem_reg_write = 1; mem_rd = 3; ex_rs1 = 3;
        tick(); tick(); #1;
        chk("rst_ctl", ctl, 8'h1C);
        chk("rst_fwd", rs1_sel, 2'b00);
        chk("rst_cnt", stall_cnt, 0);
        chk("rst_tmo", mdu_timeout, 0);
        rst = 0; idle(); #1;
        chk("idle_ctl", ctl, 8'h00);

        // Load-use: EX lw x5 ; ID add x6,x5,x1
        ex_valid = 1; ex_mem_read = 1; ex_rd = 5;
        id_valid = 1; id_rs1 = 5; id_rs1_used = 1; id_rs2 = 1; id_rs2_used = 1; #1;
        chk("lu_ctl", ctl, 8'hC8);
        tick();
        // add in EX, bubble in MEM, lw in WB
        idle();
        ex_valid = 1; ex_rs1 = 5; ex_rs2 = 1;
        wb_valid = 1; wb_reg_write = 1; wb_rd = 5; #1;
        chk("lu_after_ctl", ctl, 8'h00);
        chk("lu_rs1_sel", rs1_sel, 2'b10);
        chk("lu_rs2_sel", rs2_sel, 2'b00);
        chk("lu_cnt", stall_cnt, 1);
        // Load to x0 never stalls; unused rs2 match never stalls
        idle();
        ex_valid = 1; ex_mem_read = 1; ex_rd = 0;
        id_valid = 1; id_rs1 = 0; id_rs1_used = 1; #1;
        chk("lu_x0", ctl, 8'h00);
        ex_rd = 7; id_rs1 = 2; id_rs2 = 7; id_rs2_used = 0; #1;
        chk("lu_unused", ctl, 8'h00);
        id_rs2_used = 1; #1;
        chk("lu_rs2", ctl, 8'hC8);
        tick(); idle();

        // Forwarding priority
        mem_valid = 1; mem_reg_write = 1; mem_rd = 3;
        wb_valid = 1; wb_reg_write = 1; wb_rd = 3; ex_rs1 = 3; ex_rs2 = 3; #1;
        chk("fwd_mem", rs1_sel, 2'b01);
        chk("fwd_mem2", rs2_sel, 2'b01);
        mem_reg_write = 0; #1;
        chk("fwd_wb", rs1_sel, 2'b10);
        mem_reg_write = 1; mem_rd = 0; wb_rd = 0; ex_rs1 = 0; #1;
        chk("fwd_x0", rs1_sel, 2'b00);
        idle();

        // Mispredict with 3-cycle flush; MDU request ignored while flushing
        ex_valid = 1; ex_mispredict = 1; #1;
        chk("mp_c0", ctl, 8'h18);
        tick();
        ex_mispredict = 0; ex_is_mdu = 1; #1;
        chk("mp_c1", ctl, 8'h10);
        tick();
        chk("mp_c2", ctl, 8'h10);
        tick();
        ex_is_mdu = 0; #1;
        chk("mp_c3", ctl, 8'h00);
        idle();

        // Trap beats mispredict; trap in FLUSH restarts the count
        trap = 1; ex_valid = 1; ex_mispredict = 1; #1;
        chk("tr_c0", ctl, 8'h1C);
        tick(); idle(); #1;
        chk("tr_c1", ctl, 8'h10);
        trap = 1; #1;
        chk("tr_retrap", ctl, 8'h1C);
        tick(); trap = 0; #1;
        chk("tr_r1", ctl, 8'h10);
        tick();
        chk("tr_r2", ctl, 8'h10);
        tick();
        chk("tr_end", ctl, 8'h00);
        chk("cnt_pre_mdu", stall_cnt, 2);

        // MDU with done five cycles after start
        ex_valid = 1; ex_is_mdu = 1; #1;
        chk("mdu_t0", ctl, 8'hE6);
        tick();
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("mdu_t%0d", i), ctl, 8'hE4);
            tick();
        end
        mdu_done = 1; #1;
        chk("mdu_t5", ctl, 8'h00);
        tick(); idle(); #1;
        chk("mdu_cnt", stall_cnt, 7);

        // Watchdog: no done, abort in busy cycle 8
        ex_valid = 1; ex_is_mdu = 1; #1;
        chk("to_t0", ctl, 8'hE6);
        tick();
        for (int i = 1; i <= 7; i++) begin
            chk($sformatf("to_b%0d", i), ctl, 8'hE4);
            tick();
        end
        chk("to_b8", ctl, 8'h05);
        chk("to_flag_pre", mdu_timeout, 0);
        tick(); idle(); #1;
        chk("to_flag", mdu_timeout, 1);
        chk("to_cnt", stall_cnt, 15);
        tick(); tick();
        chk("to_sticky", mdu_timeout, 1);

        // Trap during MDU_BUSY
        ex_valid = 1; ex_is_mdu = 1; #1;
        tick();
        chk("mt_b1", ctl, 8'hE4);
        tick();
        trap = 1; mdu_done = 1; #1;
        chk("mt_trap", ctl, 8'h1D);
        tick(); idle(); #1;
        chk("mt_f1", ctl, 8'h10);
        tick();
        chk("mt_f2", ctl, 8'h10);
        tick();
        chk("mt_run", ctl, 8'h00);
        chk("mt_cnt", stall_cnt, 17);

        // Reset in the middle of a busy op
        ex_valid = 1; ex_is_mdu = 1; #1;
        tick();
        chk("rb_b1", ctl, 8'hE4);
        rst = 1; #1;
        chk("rb_rst_ctl", ctl, 8'h1C);
        tick();
        rst = 0; idle(); #1;
        chk("rb_ctl", ctl, 8'h00);
        chk("rb_cnt", stall_cnt, 0);
        chk("rb_tmo", mdu_timeout, 0);
        // Fresh op after reset: busy counter starts from zero
        ex_valid = 1; ex_is_mdu = 1; #1;
        tick();
        for (int i = 1; i <= 7; i++) tick();
        chk("rb_to_b8", ctl, 8'h05);
        tick(); idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
